// File: rtl/data_memory_arb.sv
// data_memory_arb: shared LSU data memory, round-robin arbitrated over per-channel
// read/write ports into one fixed-latency access port. Optional macro DMEM_ADDR_CHECK_EN.
module data_memory_arb #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned LATENCY      = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_addr,
    output logic [NUM_CHANNELS-1:0]           mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_addr,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_ready,
    output logic                              busy
`ifdef DMEM_ADDR_CHECK_EN
    ,
    output logic [NUM_CHANNELS-1:0]           mem_err
`endif
);

    localparam int unsigned NUM_SLOTS = 2 * NUM_CHANNELS;
    localparam int unsigned SLOT_BITS = $clog2(NUM_SLOTS);
    localparam int unsigned CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic [SLOT_BITS-1:0]   rr_ptr;
    logic [SLOT_BITS-1:0]   acc_slot;
    logic [ADDR_BITS-1:0]   acc_addr;
    logic [DATA_BITS-1:0]   acc_wdata;
    logic [CNT_BITS-1:0]    cnt;

    logic [NUM_SLOTS-1:0]   eligible;
    logic                   grant_found;
    logic [SLOT_BITS-1:0]   grant_slot;
    logic [CH_BITS-1:0]     grant_ch;
    logic [ADDR_BITS-1:0]   grant_addr;
    logic [DATA_BITS-1:0]   grant_wdata;

    logic [CH_BITS-1:0]     acc_ch;
    logic [IDX_BITS-1:0]    acc_idx;
    logic                   acc_done;
    logic                   acc_in_range;
    logic                   do_write;
    logic [DATA_BITS-1:0]   rd_value;

    logic [DATA_BITS-1:0]   mem [DEPTH];

    // Slot index base+off, wrapped into 0..NUM_SLOTS-1 (slot count need not be a power of two)
    function automatic logic [SLOT_BITS-1:0] slot_after(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NUM_SLOTS) begin
            s = s - NUM_SLOTS;
        end
        return SLOT_BITS'(s);
    endfunction

    // Array index; modulo reduces to the low bits when DEPTH is a power of two
    function automatic logic [IDX_BITS-1:0] mem_index(input logic [ADDR_BITS-1:0] a);
        return IDX_BITS'(32'(a) % DEPTH);
    endfunction

    // A slot whose ready is high this cycle is still showing the old valid; skip it
    always_comb begin
        eligible = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            eligible[2*c]   = mem_read_valid[c]  & ~mem_read_ready[c];
            eligible[2*c+1] = mem_write_valid[c] & ~mem_write_ready[c];
        end
    end

    // Round-robin pick: first eligible slot at or after rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_slot  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!grant_found && eligible[slot_after(32'(rr_ptr), i)]) begin
                grant_found = 1'b1;
                grant_slot  = slot_after(32'(rr_ptr), i);
            end
        end
        grant_ch    = CH_BITS'(grant_slot >> 1);
        grant_addr  = grant_slot[0] ? mem_write_addr[32'(grant_ch)*ADDR_BITS +: ADDR_BITS]
                                    : mem_read_addr[32'(grant_ch)*ADDR_BITS +: ADDR_BITS];
        grant_wdata = mem_write_data[32'(grant_ch)*DATA_BITS +: DATA_BITS];
    end

    always_comb begin
        acc_ch   = CH_BITS'(acc_slot >> 1);
        acc_idx  = mem_index(acc_addr);
        acc_done = (state == BUSY) && (cnt == '0);
`ifdef DMEM_ADDR_CHECK_EN
        acc_in_range = (32'(acc_addr) < DEPTH);
`else
        acc_in_range = 1'b1;
`endif
        do_write = acc_done & acc_slot[0] & acc_in_range;
        rd_value = acc_in_range ? mem[acc_idx] : '0;
    end

    // Data store: not reset; a write lands on the same edge its ready rises
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Access FSM with registered completion pulses and held read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            acc_slot        <= '0;
            acc_addr        <= '0;
            acc_wdata       <= '0;
            cnt             <= '0;
            busy            <= 1'b0;
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            mem_read_data   <= '0;
`ifdef DMEM_ADDR_CHECK_EN
            mem_err         <= '0;
`endif
        end else begin
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
`ifdef DMEM_ADDR_CHECK_EN
            mem_err         <= '0;
`endif
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        acc_slot  <= grant_slot;
                        acc_addr  <= grant_addr;
                        acc_wdata <= grant_wdata;
                        cnt       <= CNT_BITS'(LATENCY - 1);
                        rr_ptr    <= slot_after(32'(grant_slot), 1);
                        busy      <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_BITS'(1);
                    end else begin
                        if (acc_slot[0]) begin
                            mem_write_ready[acc_ch] <= 1'b1;
                        end else begin
                            mem_read_ready[acc_ch] <= 1'b1;
                            mem_read_data[32'(acc_ch)*DATA_BITS +: DATA_BITS] <= rd_value;
                        end
`ifdef DMEM_ADDR_CHECK_EN
                        mem_err[acc_ch] <= ~acc_in_range;
`endif
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arb.sv
// Directed bench for data_memory_arb: a default 4-channel instance plus LATENCY=3
// and DEPTH=128 single-channel instances; follows DMEM_ADDR_CHECK_EN when defined.
module tb_data_memory_arb;

    typedef struct {
        bit         is_wr;
        int         ch;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } txn_t;

    logic clk;
    logic reset_n;

    logic [3:0]  m_rv, m_wv, m_rr, m_wr;
    logic [31:0] m_ra, m_wa, m_wd, m_rd;
    logic        m_busy;

    logic        l3_rv, l3_wv, l3_rr, l3_wr, l3_busy;
    logic [7:0]  l3_ra, l3_wa, l3_wd, l3_rd;

    logic        d_rv, d_wv, d_rr, d_wr, d_busy;
    logic [7:0]  d_ra, d_wa, d_wd, d_rd;

`ifdef DMEM_ADDR_CHECK_EN
    logic [3:0]  m_err;
    logic        l3_err, d_err;
`endif

    int checks = 0;
    int errors = 0;

    txn_t       vec [12];
    txn_t       t;
    logic [3:0] exp_rr;
    logic [7:0] e10, e90, eff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_memory_arb u_dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read_valid(m_rv), .mem_read_addr(m_ra), .mem_read_ready(m_rr), .mem_read_data(m_rd),
        .mem_write_valid(m_wv), .mem_write_addr(m_wa), .mem_write_data(m_wd),
        .mem_write_ready(m_wr), .busy(m_busy)
`ifdef DMEM_ADDR_CHECK_EN
        , .mem_err(m_err)
`endif
    );

    data_memory_arb #(.NUM_CHANNELS(1), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n),
        .mem_read_valid(l3_rv), .mem_read_addr(l3_ra), .mem_read_ready(l3_rr), .mem_read_data(l3_rd),
        .mem_write_valid(l3_wv), .mem_write_addr(l3_wa), .mem_write_data(l3_wd),
        .mem_write_ready(l3_wr), .busy(l3_busy)
`ifdef DMEM_ADDR_CHECK_EN
        , .mem_err(l3_err)
`endif
    );

    data_memory_arb #(.NUM_CHANNELS(1), .DEPTH(128)) u_d128 (
        .clk(clk), .reset_n(reset_n),
        .mem_read_valid(d_rv), .mem_read_addr(d_ra), .mem_read_ready(d_rr), .mem_read_data(d_rd),
        .mem_write_valid(d_wv), .mem_write_addr(d_wa), .mem_write_data(d_wd),
        .mem_write_ready(d_wr), .busy(d_busy)
`ifdef DMEM_ADDR_CHECK_EN
        , .mem_err(d_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_rready", 32'(m_rr), 32'h0);
        check("rst_wready", 32'(m_wr), 32'h0);
        check("rst_rdata", m_rd, 32'h0);
        check("rst_busy", 32'(m_busy), 32'h0);
        reset_n = 1'b1;
    endtask

    // Single transaction on the 4-channel instance (LATENCY=1, so ready 2 negedges after drive)
    task automatic m_txn(input txn_t x);
        int         n;
        bit         got;
        logic [7:0] exp_vec;
        @(negedge clk);
        if (x.is_wr) begin
            m_wa[x.ch*8 +: 8] = x.addr;
            m_wd[x.ch*8 +: 8] = x.wdata;
            m_wv[x.ch] = 1'b1;
        end else begin
            m_ra[x.ch*8 +: 8] = x.addr;
            m_rv[x.ch] = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = x.is_wr ? m_wr[x.ch] : m_rr[x.ch];
        end
        check("m_latency", 32'(n), 32'd2);
        exp_vec = 8'h01 << (x.is_wr ? 4 + x.ch : x.ch);
        check("m_ready_vec", 32'({m_wr, m_rr}), 32'(exp_vec));
        if (!x.is_wr) check("m_rdata", 32'(m_rd[x.ch*8 +: 8]), 32'(x.exp));
`ifdef DMEM_ADDR_CHECK_EN
        check("m_err", 32'(m_err), 32'h0);
`endif
        m_rv = 4'h0;
        m_wv = 4'h0;
        @(negedge clk);
        check("m_pulse", 32'({m_wr, m_rr}), 32'h0);
        if (!x.is_wr) check("m_rdata_hold", 32'(m_rd[x.ch*8 +: 8]), 32'(x.exp));
    endtask

    task automatic s_drive(input int which, input bit rv, input bit wv,
                           input logic [7:0] addr, input logic [7:0] wd);
        if (which == 0) begin
            l3_rv = rv; l3_wv = wv; l3_ra = addr; l3_wa = addr; l3_wd = wd;
        end else begin
            d_rv = rv; d_wv = wv; d_ra = addr; d_wa = addr; d_wd = wd;
        end
    endtask

    // Single transaction on a single-channel instance (0: LATENCY=3, 1: DEPTH=128)
    task automatic s_txn(input int which, input bit is_wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp, input int lat);
        int         n;
        bit         got;
        logic [7:0] rd;
        @(negedge clk);
        s_drive(which, !is_wr, is_wr, addr, wdata);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = (which == 0) ? (is_wr ? l3_wr : l3_rr) : (is_wr ? d_wr : d_rr);
        end
        check("s_latency", 32'(n), 32'(lat));
        rd = (which == 0) ? l3_rd : d_rd;
        if (!is_wr) check("s_rdata", 32'(rd), 32'(exp));
`ifdef DMEM_ADDR_CHECK_EN
        check("s_err", 32'((which == 0) ? l3_err : d_err),
              32'((which == 1 && addr >= 8'h80) ? 1 : 0));
`endif
        s_drive(which, 1'b0, 1'b0, addr, wdata);
        @(negedge clk);
        got = (which == 0) ? (l3_wr | l3_rr) : (d_wr | d_rr);
        check("s_pulse", 32'(got), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{1'b1, 0, 8'h10, 8'hA5, 8'h00};
        vec[1]  = '{1'b0, 1, 8'h10, 8'h00, 8'hA5};
        vec[2]  = '{1'b1, 3, 8'hFF, 8'h5A, 8'h00};
        vec[3]  = '{1'b0, 2, 8'hFF, 8'h00, 8'h5A};
        vec[4]  = '{1'b1, 1, 8'h00, 8'h01, 8'h00};
        vec[5]  = '{1'b0, 3, 8'h00, 8'h00, 8'h01};
        vec[6]  = '{1'b1, 2, 8'h20, 8'h00, 8'h00};
        vec[7]  = '{1'b1, 0, 8'h30, 8'h11, 8'h00};
        vec[8]  = '{1'b1, 1, 8'h31, 8'h22, 8'h00};
        vec[9]  = '{1'b1, 2, 8'h32, 8'h33, 8'h00};
        vec[10] = '{1'b1, 3, 8'h33, 8'h44, 8'h00};
        vec[11] = '{1'b0, 0, 8'h10, 8'h00, 8'hA5};

        reset_n = 1'b0;
        m_rv = '0; m_wv = '0; m_ra = '0; m_wa = '0; m_wd = '0;
        l3_rv = 1'b0; l3_wv = 1'b0; l3_ra = '0; l3_wa = '0; l3_wd = '0;
        d_rv = 1'b0; d_wv = 1'b0; d_ra = '0; d_wa = '0; d_wd = '0;

        do_reset();
        check("rst_l3_busy", 32'(l3_busy), 32'h0);
        check("rst_d_busy", 32'(d_busy), 32'h0);

        // Single-requester write/read vectors
        for (int i = 0; i < 12; i++) begin
            m_txn(vec[i]);
        end

        // All four channels read at once from pointer 0
        do_reset();
        @(negedge clk);
        m_ra = {8'h33, 8'h32, 8'h31, 8'h30};
        m_rv = 4'hF;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            exp_rr = (n % 2 == 0 && n <= 8) ? 4'(1 << (n / 2 - 1)) : 4'h0;
            check("t2_ready", 32'(m_rr), 32'(exp_rr));
            check("t2_busy", 32'(m_busy), 32'((n % 2 == 1 && n <= 7) ? 1 : 0));
            m_rv = m_rv & ~m_rr;
        end
        check("t2_data", m_rd, 32'h44332211);

        // Valid held one cycle past ready is served once; pointer then favours ch3 over ch0
        do_reset();
        @(negedge clk);
        m_ra[23:16] = 8'h32;
        m_rv = 4'b0100;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check("t3_ready", 32'(m_rr), 32'((n == 2) ? 4'b0100 : 4'b0000));
            check("t3_busy", 32'(m_busy), 32'((n == 1) ? 1 : 0));
            if (n == 3) m_rv = 4'h0;
        end
        check("t3_data", 32'(m_rd[23:16]), 32'h33);
        m_ra[7:0] = 8'h30;
        m_ra[31:24] = 8'h33;
        m_rv = 4'b1001;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            exp_rr = (n == 2) ? 4'b1000 : ((n == 4) ? 4'b0001 : 4'b0000);
            check("t3_rr_order", 32'(m_rr), 32'(exp_rr));
            m_rv = m_rv & ~m_rr;
        end

        // Same-channel read and write to one address: read slot first from pointer 0
        do_reset();
        @(negedge clk);
        m_ra[7:0] = 8'h20;
        m_wa[7:0] = 8'h20;
        m_wd[7:0] = 8'h3C;
        m_rv = 4'b0001;
        m_wv = 4'b0001;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            check("t4_rready", 32'(m_rr), 32'((n == 2) ? 1 : 0));
            check("t4_wready", 32'(m_wr), 32'((n == 4) ? 1 : 0));
            if (n == 2) begin
                check("t4_old_data", 32'(m_rd[7:0]), 32'h00);
                m_rv = 4'h0;
            end
            if (n == 4) m_wv = 4'h0;
        end
        t = '{1'b0, 0, 8'h20, 8'h00, 8'h3C};
        m_txn(t);

        // LATENCY=3 instance: normal accesses, then reset during the second BUSY cycle
        s_txn(0, 1'b1, 8'h40, 8'h00, 8'h00, 4);
        s_txn(0, 1'b1, 8'h41, 8'h99, 8'h00, 4);
        s_txn(0, 1'b0, 8'h41, 8'h00, 8'h99, 4);
        @(negedge clk);
        s_drive(0, 1'b0, 1'b1, 8'h40, 8'h77);
        @(negedge clk);
        check("t5_busy1", 32'(l3_busy), 32'h1);
        @(negedge clk);
        check("t5_busy2", 32'(l3_busy), 32'h1);
        check("t5_noready_pre", 32'(l3_wr), 32'h0);
        reset_n = 1'b0;
        #1;
        check("t5_busy_rst", 32'(l3_busy), 32'h0);
        s_drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("t5_noready", 32'({l3_wr, l3_rr}), 32'h0);
            check("t5_idle", 32'(l3_busy), 32'h0);
        end
        s_txn(0, 1'b0, 8'h40, 8'h00, 8'h00, 4);

        // DEPTH=128 instance: out-of-range addresses
`ifdef DMEM_ADDR_CHECK_EN
        e10 = 8'hC3; e90 = 8'h00; eff = 8'h00;
`else
        e10 = 8'h5E; e90 = 8'h5E; eff = 8'h66;
`endif
        s_txn(1, 1'b1, 8'h10, 8'hC3, 8'h00, 2);
        s_txn(1, 1'b1, 8'h7F, 8'h66, 8'h00, 2);
        s_txn(1, 1'b1, 8'h90, 8'h5E, 8'h00, 2);
        s_txn(1, 1'b0, 8'h10, 8'h00, e10, 2);
        s_txn(1, 1'b0, 8'h90, 8'h00, e90, 2);
        s_txn(1, 1'b0, 8'hFF, 8'h00, eff, 2);
        s_txn(1, 1'b0, 8'h7F, 8'h00, 8'h66, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
